// File: rtl/dcache_ctrl.sv
// Data-cache miss controller: optional dirty-victim writeback, then line fill
// through a nibble-wide line buffer, then reload of the cache array.
module dcache_ctrl #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22,
  localparam int LB         = $clog2(LINE_LENGTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_req,
  input  logic           fault,
  input  logic           hit,
  input  logic           push,
  input  logic           pull,
  input  logic [PA-LB-1:0] fill_line,
  input  logic [PA-LB-1:0] victim_line,
  input  logic [3:0]     dwrite,
  output logic           rstrobe_d,
  output logic           wstrobe_d,
  output logic [3:0]     dread,
  output logic           cpu_stall,
  output logic           mem_req,
  output logic           mem_write,
  output logic [PA-1:0]  mem_addr,
  input  logic           mem_gnt,
  input  logic           mem_nstrobe,
  output logic [3:0]     mem_wdata,
  input  logic [3:0]     mem_rdata
);
  localparam int N  = 2 * LINE_LENGTH;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE, WB_DRAIN, WB_ADDR, WB_DATA, FILL_ADDR, FILL_DATA, FILL_LOAD, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    buf_q [N];
  logic          buf_we;
  logic [3:0]    buf_wdata;
  logic          miss;

  // pull is implied by a miss; the controller does not need it separately
  logic unused_pull;
  assign unused_pull = pull;

  assign miss      = cpu_req && !fault && !hit;
  assign cpu_stall = (state_q != IDLE) || miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Line buffer holds data only; it is never cleared.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q] <= buf_wdata;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_we    = 1'b0;
    buf_wdata = dwrite;
    rstrobe_d = 1'b0;
    wstrobe_d = 1'b0;
    dread     = '0;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (miss) state_d = push ? WB_DRAIN : FILL_ADDR;
      end
      WB_DRAIN: begin
        rstrobe_d = 1'b1;
        buf_we    = 1'b1;
        buf_wdata = dwrite;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = WB_ADDR;
          cnt_d   = '0;
        end
      end
      WB_ADDR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        mem_addr  = PA'(victim_line) << LB;
        if (mem_gnt) begin
          state_d = WB_DATA;
          cnt_d   = '0;
        end
      end
      WB_DATA: begin
        mem_wdata = buf_q[cnt_q];
        if (mem_nstrobe) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = FILL_ADDR;
            cnt_d   = '0;
          end
        end
      end
      FILL_ADDR: begin
        mem_req  = 1'b1;
        mem_addr = PA'(fill_line) << LB;
        if (mem_gnt) begin
          state_d = FILL_DATA;
          cnt_d   = '0;
        end
      end
      FILL_DATA: begin
        // strobes only count here, so one arriving with the grant is dropped
        if (mem_nstrobe) begin
          buf_we    = 1'b1;
          buf_wdata = mem_rdata;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = FILL_LOAD;
            cnt_d   = '0;
          end
        end
      end
      FILL_LOAD: begin
        wstrobe_d = 1'b1;
        dread     = buf_q[cnt_q];
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: directed and randomized miss transactions checked
// against a nibble-queue model of writeback and fill traffic.
module tb_dcache_ctrl;
  localparam int LL = 4;
  localparam int PA = 22;
  localparam int LB = 2;
  localparam int N  = 2 * LL;
  localparam int LW = PA - LB;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, fault, hit, push, pull;
  logic [LW-1:0] fill_line, victim_line;
  logic [3:0]    dwrite;
  logic          rstrobe_d, wstrobe_d;
  logic [3:0]    dread;
  logic          cpu_stall, mem_req, mem_write;
  logic [PA-1:0] mem_addr;
  logic          mem_gnt, mem_nstrobe;
  logic [3:0]    mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;
  bit noise = 1'b0;

  dcache_ctrl #(.LINE_LENGTH(LL), .PA(PA)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .fault(fault), .hit(hit),
    .push(push), .pull(pull), .fill_line(fill_line), .victim_line(victim_line),
    .dwrite(dwrite), .rstrobe_d(rstrobe_d), .wstrobe_d(wstrobe_d), .dread(dread),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_nstrobe(mem_nstrobe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (noise) begin
      cpu_req = 1'($urandom);
      fault   = 1'($urandom);
      hit     = 1'($urandom);
    end
  endtask

  task automatic addr_phase(input bit wr, input logic [LW-1:0] line, input int gw, input bit sg);
    logic [PA-1:0] ea;
    ea = PA'(line) * PA'(LL);
    for (int w = 0; w < gw; w++) begin
      mem_nstrobe = 1'($urandom);
      #1;
      chk("addr_req", 32'(mem_req), 1);
      chk("addr_write", 32'(mem_write), 32'(wr));
      chk("addr_addr", 32'(mem_addr), 32'(ea));
      chk("addr_wdata", 32'(mem_wdata), 0);
      step();
    end
    mem_gnt = 1'b1;
    mem_nstrobe = sg;
    #1;
    chk("gnt_req", 32'(mem_req), 1);
    chk("gnt_addr", 32'(mem_addr), 32'(ea));
    step();
    mem_gnt = 1'b0;
    mem_nstrobe = 1'b0;
  endtask

  task automatic do_miss(input bit dirty, input logic [LW-1:0] vline, input logic [LW-1:0] fline,
                         input int gw_wb, input int gw_fill, input int gap_max,
                         input bit seq, input bit strobe_gnt);
    logic [3:0] wq[$];
    logic [3:0] rq[$];
    logic [3:0] nib;
    int g;
    cpu_req = 1'b1; hit = 1'b0; fault = 1'b0; pull = 1'b1; push = dirty;
    victim_line = vline; fill_line = fline;
    #1;
    chk("start_stall", 32'(cpu_stall), 1);
    chk("start_req", 32'(mem_req), 0);
    noise = 1'b1;
    step();
    push = 1'b0;
    if (dirty) begin
      for (int i = 0; i < N; i++) begin
        nib = seq ? 4'(8 + i) : 4'($urandom);
        dwrite = nib;
        wq.push_back(nib);
        #1;
        chk("drain_rstrobe", 32'(rstrobe_d), 1);
        chk("drain_req", 32'(mem_req), 0);
        chk("drain_stall", 32'(cpu_stall), 1);
        step();
      end
      dwrite = 4'h0;
      #1;
      chk("drain_end", 32'(rstrobe_d), 0);
      addr_phase(1'b1, vline, gw_wb, strobe_gnt);
      for (int i = 0; i < N; i++) begin
        g = seq ? 1 : $urandom_range(0, gap_max);
        for (int k = 0; k < g; k++) begin
          #1;
          chk("wb_gap_wdata", 32'(mem_wdata), 32'(wq[i]));
          chk("wb_gap_req", 32'(mem_req), 0);
          step();
        end
        mem_nstrobe = 1'b1;
        #1;
        chk("wb_wdata", 32'(mem_wdata), 32'(wq[i]));
        chk("wb_rstrobe", 32'(rstrobe_d), 0);
        step();
        mem_nstrobe = 1'b0;
      end
    end
    addr_phase(1'b0, fline, gw_fill, strobe_gnt);
    for (int i = 0; i < N; i++) begin
      g = seq ? 1 : $urandom_range(0, gap_max);
      for (int k = 0; k < g; k++) begin
        mem_rdata = 4'($urandom);
        #1;
        chk("fill_gap_wstrobe", 32'(wstrobe_d), 0);
        chk("fill_gap_req", 32'(mem_req), 0);
        step();
      end
      nib = seq ? 4'(i + 1) : 4'($urandom);
      rq.push_back(nib);
      mem_rdata = nib;
      mem_nstrobe = 1'b1;
      #1;
      chk("fill_wstrobe", 32'(wstrobe_d), 0);
      chk("fill_dread", 32'(dread), 0);
      step();
      mem_nstrobe = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      #1;
      chk("load_wstrobe", 32'(wstrobe_d), 1);
      chk("load_dread", 32'(dread), 32'(rq[i]));
      chk("load_stall", 32'(cpu_stall), 1);
      step();
    end
    #1;
    chk("done_wstrobe", 32'(wstrobe_d), 0);
    chk("done_stall", 32'(cpu_stall), 1);
    chk("done_req", 32'(mem_req), 0);
    noise = 1'b0;
    step();
    cpu_req = 1'b0; fault = 1'b0; hit = 1'b0;
    #1;
    chk("idle_stall", 32'(cpu_stall), 0);
    chk("idle_req", 32'(mem_req), 0);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; fault = 0; hit = 0; push = 0; pull = 0;
    fill_line = '0; victim_line = '0; dwrite = '0;
    mem_gnt = 0; mem_nstrobe = 0; mem_rdata = '0;
    #1;
    chk("rst_rstrobe", 32'(rstrobe_d), 0);
    chk("rst_wstrobe", 32'(wstrobe_d), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_stall", 32'(cpu_stall), 0);
    step(); step();
    reset = 1'b0;

    // hit never stalls
    cpu_req = 1'b1; hit = 1'b1; pull = 1'b1;
    #1;
    chk("hit_stall", 32'(cpu_stall), 0);
    chk("hit_req", 32'(mem_req), 0);
    step();
    chk("hit_req_next", 32'(mem_req), 0);

    // faulted miss never starts
    hit = 1'b0; fault = 1'b1;
    #1;
    chk("fault_stall", 32'(cpu_stall), 0);
    chk("fault_req", 32'(mem_req), 0);
    step();
    #1;
    chk("fault_req_next", 32'(mem_req), 0);
    chk("fault_rstrobe", 32'(rstrobe_d), 0);
    cpu_req = 1'b0; fault = 1'b0;
    step();

    do_miss(1'b0, '0, 20'h12345, 0, 2, 1, 1'b1, 1'b0);
    do_miss(1'b1, 20'h00001, 20'h12345, 1, 2, 1, 1'b1, 1'b0);
    do_miss(1'b0, '0, 20'h0ABCD, 0, 1, 0, 1'b0, 1'b1);

    // reset in FILL_DATA after three nibbles
    cpu_req = 1'b1; hit = 1'b0; fault = 1'b0; push = 1'b0; fill_line = 20'hFEDCB;
    step();
    cpu_req = 1'b0;
    mem_gnt = 1'b1;
    #1;
    chk("rstmid_gnt_req", 32'(mem_req), 1);
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_nstrobe = 1'b1; mem_rdata = 4'(i);
      step();
    end
    mem_nstrobe = 1'b0;
    #1;
    chk("rstmid_pre_stall", 32'(cpu_stall), 1);
    reset = 1'b1;
    #1;
    chk("rstmid_rstrobe", 32'(rstrobe_d), 0);
    chk("rstmid_wstrobe", 32'(wstrobe_d), 0);
    chk("rstmid_dread", 32'(dread), 0);
    chk("rstmid_req", 32'(mem_req), 0);
    chk("rstmid_write", 32'(mem_write), 0);
    chk("rstmid_addr", 32'(mem_addr), 0);
    chk("rstmid_wdata", 32'(mem_wdata), 0);
    chk("rstmid_stall", 32'(cpu_stall), 0);
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      mem_nstrobe = 1'b1;
      #1;
      chk("post_rst_wstrobe", 32'(wstrobe_d), 0);
      chk("post_rst_req", 32'(mem_req), 0);
      step();
    end
    mem_nstrobe = 1'b0;
    do_miss(1'b1, 20'h5A5A5, 20'hA5A5A, 0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      do_miss(1'($urandom), 20'($urandom), 20'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
              1'b0, 1'($urandom));
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 4, line length in bytes (line = 2*LINE_LENGTH nibbles).
REQ-002 SHALL have parameter PA, default 22, physical address width; LB = clog2(LINE_LENGTH).
REQ-003 SHALL have ports (name  dir  width  meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  load/store presented this cycle
- fault  in  1  access faulted; never serviced
- hit  in  1  cache hit for current access
- push  in  1  victim line dirty, write back before fill
- pull  in  1  line fill required
- fill_line  in  PA-LB  line address of missing line
- victim_line  in  PA-LB  line address of dirty victim
- dwrite  in  4  cache nibble at current cache offset
- rstrobe_d  out  1  consume one nibble from cache
- wstrobe_d  out  1  write one nibble into cache
- dread  out  4  nibble written into cache
- cpu_stall  out  1  hold the pipeline
- mem_req  out  1  memory transaction request
- mem_write  out  1  1 = writeback, 0 = fill
- mem_addr  out  PA  line-aligned address, low LB bits 0
- mem_gnt  in  1  memory accepts address this cycle
- mem_nstrobe  in  1  one nibble transferred this cycle
- mem_wdata  out  4  writeback nibble
- mem_rdata  in  4  fill nibble

Function
REQ-004 SHALL implement states IDLE, WB_DRAIN, WB_ADDR, WB_DATA, FILL_ADDR, FILL_DATA, FILL_LOAD, DONE, plus nibble counter cnt (clog2(2*LINE_LENGTH) bits) and a 2*LINE_LENGTH-nibble line buffer.
REQ-005 SHALL define miss = cpu_req && !fault && !hit.
REQ-006 IDLE: miss && push -> WB_DRAIN; miss && !push -> FILL_ADDR; else stay. cnt = 0 on every state entry.
REQ-007 WB_DRAIN SHALL assert rstrobe_d on 2*LINE_LENGTH consecutive cycles with no gaps, capturing dwrite into buffer[cnt] each cycle; after the last nibble -> WB_ADDR.
REQ-008 WB_ADDR/FILL_ADDR SHALL hold mem_req=1 and mem_addr = {victim_line or fill_line, LB zeros}; mem_write=1 in WB_ADDR, 0 in FILL_ADDR; on mem_gnt -> WB_DATA/FILL_DATA.
REQ-009 mem_nstrobe SHALL be ignored outside WB_DATA and FILL_DATA, including the mem_gnt cycle.
REQ-010 WB_DATA SHALL drive mem_wdata = buffer[cnt]; each mem_nstrobe advances cnt; the strobe on cnt = 2*LINE_LENGTH-1 -> FILL_ADDR.
REQ-011 FILL_DATA SHALL capture mem_rdata into buffer[cnt] on each mem_nstrobe; gaps between strobes are allowed; the last nibble -> FILL_LOAD.
REQ-012 FILL_LOAD SHALL assert wstrobe_d with dread = buffer[cnt] on 2*LINE_LENGTH consecutive cycles, nibble 0 first, no gaps; then -> DONE.
REQ-013 DONE SHALL last exactly one cycle, then -> IDLE.
REQ-014 cpu_stall SHALL equal (state != IDLE) || miss, combinationally.
REQ-015 fault=1 SHALL suppress any transaction start; faults arriving after a transaction has started SHALL be ignored.
REQ-016 mem_req, rstrobe_d and wstrobe_d SHALL be 0 in every state where they are not required above; mem_addr, mem_write, mem_wdata and dread SHALL be 0 when mem_req, mem_req, WB_DATA and wstrobe_d respectively are inactive.
REQ-017 Minimum clean-fill latency SHALL be (1 + gnt wait + 2*LINE_LENGTH nibble cycles + 2*LINE_LENGTH + 1) cycles.

Reset
REQ-018 reset SHALL asynchronously force IDLE, cnt=0, every output 0; the buffer need not be cleared.
REQ-019 A reset mid-transaction SHALL abandon it with no further strobes; after release a new miss SHALL restart from IDLE.

Verification
REQ-020 Hit: cpu_req=1, hit=1 -> cpu_stall=0, mem_req stays 0.
REQ-021 Clean miss: pull=1, push=0, fill_line=0x12345 -> mem_addr=0x048D14, mem_write=0; gnt after 2 cycles; rdata 1..8 with one-cycle gaps -> 8 consecutive wstrobe_d with dread 1,2,...,8, DONE, then cpu_stall=0.
REQ-022 Dirty miss: push=1, victim_line=0x00001, dwrite 0x8..0xF -> 8 consecutive rstrobe_d; mem_addr=0x000004, mem_write=1; mem_wdata 8..F; then fill per REQ-021.
REQ-023 Reset in FILL_DATA after 3 nibbles -> all outputs 0 in the same cycle, state IDLE, no wstrobe_d afterwards.
REQ-024 fault=1, hit=0, pull=1 -> cpu_stall=0, mem_req=0.
REQ-025 mem_nstrobe=1 in the mem_gnt cycle -> that nibble is not counted; exactly 8 further strobes are needed to leave FILL_DATA.
